lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Execute-stage load/store unit at the receiving end of the dispatch MEM request.
- Takes the precomputed address, write mask, write data and load-type flags, and runs one transaction at a time on a valid/ready data bus.
- For loads, aligns and sign- or zero-extends the returned word and emits a one-cycle register writeback.
- Stalls the pipeline while a transaction is outstanding, and aborts or drains the transaction on flush.

Parameters:
- BUS_AW, 32, data bus address width
- BUS_DW, 32, data bus data width (fixed at 32; other values unsupported)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_mem_i  in  1  MEM-group instruction present at dispatch
- mem_op_lb_i / mem_op_lh_i / mem_op_lw_i / mem_op_lbu_i / mem_op_lhu_i  in  1 each  load type (one-hot when mem_op_load_i=1)
- mem_op_load_i  in  1  any load
- mem_op_store_i  in  1  any store
- mem_addr_i  in  32  effective address (rs1+imm)
- mem_wmask_i  in  4  store byte mask, already lane-shifted
- mem_wdata_i  in  32  store data, already lane-shifted
- rd_addr_i  in  5  load destination register
- misaligned_load_i / misaligned_store_i  in  1  misalignment flags from dispatch
- flush_i  in  1  pipeline flush (branch or trap)
- stall_o  out  1  hold dispatch; the current MEM instruction is not yet retired
- bus_req_valid_o  out  1  bus request valid
- bus_req_ready_i  in  1  bus request accepted
- bus_addr_o  out  BUS_AW  request address, word-aligned (addr[1:0]=0)
- bus_we_o  out  1  1=write, 0=read
- bus_wmask_o  out  4  byte enables (0000 on reads)
- bus_wdata_o  out  32  write data
- bus_rsp_valid_i  in  1  response valid
- bus_rdata_i  in  32  read data (full word)
- bus_rsp_err_i  in  1  bus error; qualified by bus_rsp_valid_i
- wb_valid_o  out  1  load writeback pulse
- wb_rd_o  out  5  writeback register index
- wb_data_o  out  32  extended load data
- access_fault_o  out  1  one-cycle pulse: bus error on a non-flushed transaction
- fault_addr_o  out  32  full byte address of the faulting access
- fault_is_store_o  out  1  1=store fault, 0=load fault

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every registered output 0 (bus_req_valid_o, wb_valid_o, wb_rd_o, wb_data_o, access_fault_o, fault_addr_o, fault_is_store_o, bus_addr_o, bus_we_o, bus_wmask_o, bus_wdata_o).
- Accept condition, in IDLE: accept = req_mem_i & (mem_op_load_i|mem_op_store_i) & ~misaligned_load_i & ~misaligned_store_i & ~flush_i.
- On accept, latch: addr, {addr[31:2],2'b00}, we=mem_op_store_i, wmask, wdata, rd, load type. Next state=REQ.
- Misaligned requests are never issued (the trap is raised elsewhere); no stall and no writeback.
- States:
  - IDLE: waiting for accept.
  - REQ: bus_req_valid_o=1 with stable addr/we/wmask/wdata until bus_req_ready_i. On handshake → RESP.
  - RESP: waiting for bus_rsp_valid_i, then → IDLE.
  - DRAIN: flushed while the request was in flight; on bus_rsp_valid_i → IDLE with no writeback and no fault.
- The bus guarantees the response arrives at the earliest one cycle after the handshake. A response with no outstanding request is ignored.
- flush_i:
  - in REQ before the handshake → IDLE; bus_req_valid_o drops the next cycle.
  - in REQ on the same cycle as ready → DRAIN.
  - in RESP without a response → DRAIN.
  - in RESP with the response in the same cycle: the flush wins, so the writeback and fault are suppressed and the next state is IDLE.
- stall_o (combinational) = (IDLE & accept) | REQ | DRAIN | (RESP & ~bus_rsp_valid_i). It is released in the response cycle, so dispatch advances the next cycle.
- Load extraction (registered, using latched addr[1:0]):
  - LB/LBU: byte = rdata[8*a+7:8*a].
  - LH/LHU: half = rdata[16*a1+15:16*a1].
  - LW: full word.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
- wb_valid_o=1 for exactly one cycle, the cycle after a good load response, with wb_rd_o=latched rd. It is asserted even when rd=0 (the regfile discards the write).
- Stores never assert wb_valid_o.
- On a good response with err=1: access_fault_o pulses one cycle, registered, together with fault_addr_o and fault_is_store_o. No writeback is produced. State → IDLE.
- Minimum load latency: accept at T0, request at T1 (ready=1), response at T2, wb_valid_o at T3. Back-to-back accept is possible at T3.

Test Plan:
- LW at 0x1000, ready=1, rsp at the next cycle with rdata=0xDEADBEEF → wb_valid_o at T3, wb_data_o=0xDEADBEEF, wb_rd_o=rd; stall_o high T0–T1, low at T2.
- LB at addr 0x1003 with rdata=0x80123456 → 0xFFFFFF80; LBU → 0x00000080; LH at 0x1002 → 0xFFFF8012; LHU → 0x00008012.
- SB at 0x2001, wmask=0010, wdata=0x0000AB00, ready held low 3 cycles → bus_req_valid_o stable for 4 cycles, bus_addr_o=0x2000, bus_we_o=1, no wb_valid_o.
- Flush: flush_i in REQ before ready → IDLE, no bus handshake. Flush in RESP → DRAIN; the late response with 0x1234 is consumed and produces no wb_valid_o.
- bus_rsp_err_i=1 on LW at 0x3000 → access_fault_o pulse, fault_addr_o=0x3000, fault_is_store_o=0, wb_valid_o stays 0.
- misaligned_load_i=1 on LW at 0x1002 → bus_req_valid_o and stall_o stay 0. Deassert rst_n mid-RESP → all outputs 0 immediately, state=IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// Execute-stage load/store unit. Accepts one MEM instruction from dispatch and
// runs a single transaction on a valid/ready data bus. Returned load data is
// aligned and extended, then delivered as a one-cycle register writeback.
// Dispatch is stalled while the instruction is outstanding. A flush either
// cancels the request before the bus sees it, or lets the response drain
// silently.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int BUS_AW = 32,
  parameter int BUS_DW = 32   // load extraction assumes a 32-bit word
) (
  input  logic              clk,
  input  logic              rst_n,

  // Dispatch MEM request
  input  logic              req_mem_i,
  input  logic              mem_op_lb_i,
  input  logic              mem_op_lh_i,
  input  logic              mem_op_lw_i,
  input  logic              mem_op_lbu_i,
  input  logic              mem_op_lhu_i,
  input  logic              mem_op_load_i,
  input  logic              mem_op_store_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_wmask_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              misaligned_load_i,
  input  logic              misaligned_store_i,
  input  logic              flush_i,
  output logic              stall_o,

  // Data bus request channel
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic [BUS_AW-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_wmask_o,
  output logic [BUS_DW-1:0] bus_wdata_o,

  // Data bus response channel
  input  logic              bus_rsp_valid_i,
  input  logic [BUS_DW-1:0] bus_rdata_i,
  input  logic              bus_rsp_err_i,

  // Register writeback
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,

  // Access fault report
  output logic              access_fault_o,
  output logic [31:0]       fault_addr_o,
  output logic              fault_is_store_o
);

  typedef enum logic [1:0] {
    ST_IDLE,   // waiting for an acceptable MEM instruction
    ST_REQ,    // request presented, waiting for ready
    ST_RESP,   // request accepted, waiting for the response
    ST_DRAIN   // flushed after handshake, swallow the response
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // FSM state
  state_e state_q, state_d;

  // Transaction context captured on accept
  logic [31:0]       addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;

  // Registered bus request outputs
  logic              bus_req_valid_q, bus_req_valid_d;
  logic [BUS_AW-1:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_wmask_q, bus_wmask_d;
  logic [BUS_DW-1:0] bus_wdata_q, bus_wdata_d;

  // Registered writeback and fault outputs
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              access_fault_q, access_fault_d;
  logic [31:0]       fault_addr_q, fault_addr_d;
  logic              fault_is_store_q, fault_is_store_d;

  // Decoded control
  logic              accept;
  logic              rsp_ok;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  size_e             req_size;

  // A MEM instruction is taken only from IDLE, when well-formed and not flushed.
  assign accept = (state_q == ST_IDLE) & req_mem_i
                & (mem_op_load_i | mem_op_store_i)
                & ~misaligned_load_i & ~misaligned_store_i & ~flush_i;

  // A response counts only when it completes a live (non-flushed) transaction.
  assign rsp_ok = (state_q == ST_RESP) & bus_rsp_valid_i & ~flush_i;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush and handshake priority within each state
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus_req_ready_i) begin
          // Bus has taken the request; a flush now must still eat the response.
          state_d = flush_i ? ST_DRAIN : ST_RESP;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        // A response in the flush cycle closes the transaction directly.
        if (bus_rsp_valid_i)  state_d = ST_IDLE;
        else if (flush_i)     state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus_rsp_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load type decode into access size and signedness
  always_comb begin
    req_size = SZ_WORD;
    if (mem_op_lb_i | mem_op_lbu_i)       req_size = SZ_BYTE;
    else if (mem_op_lh_i | mem_op_lhu_i)  req_size = SZ_HALF;
    else if (mem_op_lw_i)                 req_size = SZ_WORD;
  end

  // Load alignment and extension from the latched byte offset
  always_comb begin
    ld_byte = bus_rdata_i[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = bus_rdata_i[7:0];
      2'd1: ld_byte = bus_rdata_i[15:8];
      2'd2: ld_byte = bus_rdata_i[23:16];
      2'd3: ld_byte = bus_rdata_i[31:24];
      default: ld_byte = bus_rdata_i[7:0];
    endcase
    ld_half = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (size_q)
      SZ_BYTE: ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata_i[31:0];
    endcase
  end

  // Output logic: stall, registered bus request, writeback and fault pulses
  always_comb begin
    // Hold everything by default; pulses default low.
    addr_d           = addr_q;
    rd_d             = rd_q;
    size_d           = size_q;
    signed_d         = signed_q;
    bus_addr_d       = bus_addr_q;
    bus_we_d         = bus_we_q;
    bus_wmask_d      = bus_wmask_q;
    bus_wdata_d      = bus_wdata_q;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    fault_addr_d     = fault_addr_q;
    fault_is_store_d = fault_is_store_q;
    wb_valid_d       = 1'b0;
    access_fault_d   = 1'b0;

    // The request stays up exactly while the FSM sits in REQ.
    bus_req_valid_d = (state_d == ST_REQ);

    // Released in the response cycle so dispatch advances on the next edge.
    stall_o = accept
            | (state_q == ST_REQ)
            | (state_q == ST_DRAIN)
            | ((state_q == ST_RESP) & ~bus_rsp_valid_i);

    if (accept) begin
      addr_d      = mem_addr_i;
      rd_d        = rd_addr_i;
      size_d      = req_size;
      signed_d    = mem_op_lb_i | mem_op_lh_i;
      bus_addr_d  = BUS_AW'({mem_addr_i[31:2], 2'b00});
      bus_we_d    = mem_op_store_i;
      // Reads never carry byte enables.
      bus_wmask_d = mem_op_store_i ? mem_wmask_i : 4'b0000;
      bus_wdata_d = BUS_DW'(mem_wdata_i);
    end

    if (rsp_ok) begin
      if (bus_rsp_err_i) begin
        access_fault_d   = 1'b1;
        fault_addr_d     = addr_q;
        fault_is_store_d = bus_we_q;
      end else if (!bus_we_q) begin
        // rd=0 is still written back; the register file drops it.
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = ld_data;
      end
    end
  end

  // Datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q           <= '0;
      rd_q             <= '0;
      size_q           <= SZ_WORD;
      signed_q         <= 1'b0;
      bus_req_valid_q  <= 1'b0;
      bus_addr_q       <= '0;
      bus_we_q         <= 1'b0;
      bus_wmask_q      <= '0;
      bus_wdata_q      <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      access_fault_q   <= 1'b0;
      fault_addr_q     <= '0;
      fault_is_store_q <= 1'b0;
    end else begin
      addr_q           <= addr_d;
      rd_q             <= rd_d;
      size_q           <= size_d;
      signed_q         <= signed_d;
      bus_req_valid_q  <= bus_req_valid_d;
      bus_addr_q       <= bus_addr_d;
      bus_we_q         <= bus_we_d;
      bus_wmask_q      <= bus_wmask_d;
      bus_wdata_q      <= bus_wdata_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      access_fault_q   <= access_fault_d;
      fault_addr_q     <= fault_addr_d;
      fault_is_store_q <= fault_is_store_d;
    end
  end

  assign bus_req_valid_o  = bus_req_valid_q;
  assign bus_addr_o       = bus_addr_q;
  assign bus_we_o         = bus_we_q;
  assign bus_wmask_o      = bus_wmask_q;
  assign bus_wdata_o      = bus_wdata_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign access_fault_o   = access_fault_q;
  assign fault_addr_o     = fault_addr_q;
  assign fault_is_store_o = fault_is_store_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed bench for lsu_mem_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LH  = 5'b01000;
  localparam logic [4:0] OP_LW  = 5'b00100;
  localparam logic [4:0] OP_LBU = 5'b00010;
  localparam logic [4:0] OP_LHU = 5'b00001;

  logic        clk;
  logic        rst_n;
  logic        req_mem_i;
  logic        mem_op_lb_i, mem_op_lh_i, mem_op_lw_i, mem_op_lbu_i, mem_op_lhu_i;
  logic        mem_op_load_i, mem_op_store_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_wmask_i;
  logic [31:0] mem_wdata_i;
  logic [4:0]  rd_addr_i;
  logic        misaligned_load_i, misaligned_store_i;
  logic        flush_i;
  logic        stall_o;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_wmask_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rsp_valid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_rsp_err_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        access_fault_o;
  logic [31:0] fault_addr_o;
  logic        fault_is_store_o;

  int total = 0;
  int bad   = 0;

  lsu_mem_ctrl #(.BUS_AW(32), .BUS_DW(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_mem_i          (req_mem_i),
    .mem_op_lb_i        (mem_op_lb_i),
    .mem_op_lh_i        (mem_op_lh_i),
    .mem_op_lw_i        (mem_op_lw_i),
    .mem_op_lbu_i       (mem_op_lbu_i),
    .mem_op_lhu_i       (mem_op_lhu_i),
    .mem_op_load_i      (mem_op_load_i),
    .mem_op_store_i     (mem_op_store_i),
    .mem_addr_i         (mem_addr_i),
    .mem_wmask_i        (mem_wmask_i),
    .mem_wdata_i        (mem_wdata_i),
    .rd_addr_i          (rd_addr_i),
    .misaligned_load_i  (misaligned_load_i),
    .misaligned_store_i (misaligned_store_i),
    .flush_i            (flush_i),
    .stall_o            (stall_o),
    .bus_req_valid_o    (bus_req_valid_o),
    .bus_req_ready_i    (bus_req_ready_i),
    .bus_addr_o         (bus_addr_o),
    .bus_we_o           (bus_we_o),
    .bus_wmask_o        (bus_wmask_o),
    .bus_wdata_o        (bus_wdata_o),
    .bus_rsp_valid_i    (bus_rsp_valid_i),
    .bus_rdata_i        (bus_rdata_i),
    .bus_rsp_err_i      (bus_rsp_err_i),
    .wb_valid_o         (wb_valid_o),
    .wb_rd_o            (wb_rd_o),
    .wb_data_o          (wb_data_o),
    .access_fault_o     (access_fault_o),
    .fault_addr_o       (fault_addr_o),
    .fault_is_store_o   (fault_is_store_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the run stalls
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_mem_i = 1'b0;
    {mem_op_lb_i, mem_op_lh_i, mem_op_lw_i, mem_op_lbu_i, mem_op_lhu_i} = 5'b0;
    mem_op_load_i = 1'b0;  mem_op_store_i = 1'b0;
    mem_addr_i = '0;  mem_wmask_i = '0;  mem_wdata_i = '0;  rd_addr_i = '0;
    misaligned_load_i = 1'b0;  misaligned_store_i = 1'b0;  flush_i = 1'b0;
    bus_req_ready_i = 1'b0;  bus_rsp_valid_i = 1'b0;  bus_rdata_i = '0;
    bus_rsp_err_i = 1'b0;
  endtask

  task automatic present_load(input logic [31:0] addr, input logic [4:0] op, input logic [4:0] rd);
    req_mem_i = 1'b1;
    {mem_op_lb_i, mem_op_lh_i, mem_op_lw_i, mem_op_lbu_i, mem_op_lhu_i} = op;
    mem_op_load_i = 1'b1;  mem_op_store_i = 1'b0;
    mem_addr_i = addr;  rd_addr_i = rd;  mem_wmask_i = '0;  mem_wdata_i = '0;
  endtask

  // Remove the dispatch request and scramble its fields to prove they were latched
  task automatic drop_req();
    req_mem_i = 1'b0;
    {mem_op_lb_i, mem_op_lh_i, mem_op_lw_i, mem_op_lbu_i, mem_op_lhu_i} = 5'b0;
    mem_op_load_i = 1'b0;  mem_op_store_i = 1'b0;
    mem_addr_i = 32'hFFFF_FFFC;  rd_addr_i = 5'd31;
    mem_wmask_i = 4'hF;  mem_wdata_i = 32'h5555_5555;
  endtask

  // Minimum-latency load: accept T0, handshake T1, response T2, writeback T3
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [4:0] op,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    step(); present_load(addr, op, rd); bus_req_ready_i = 1'b1;
    sample(); check({tag, ".t0_stall"}, stall_o, 1);
    step(); drop_req();
    sample();
    check({tag, ".t1_valid"}, bus_req_valid_o, 1);
    check({tag, ".t1_addr"},  bus_addr_o, {addr[31:2], 2'b00});
    check({tag, ".t1_we"},    bus_we_o, 0);
    check({tag, ".t1_wmask"}, bus_wmask_o, 0);
    check({tag, ".t1_stall"}, stall_o, 1);
    step(); bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b1; bus_rdata_i = rdata;
    sample();
    check({tag, ".t2_stall"}, stall_o, 0);
    check({tag, ".t2_valid"}, bus_req_valid_o, 0);
    step(); bus_rsp_valid_i = 1'b0; bus_rdata_i = '0;
    sample();
    check({tag, ".t3_wb_valid"}, wb_valid_o, 1);
    check({tag, ".t3_wb_data"},  wb_data_o, exp);
    check({tag, ".t3_wb_rd"},    wb_rd_o, rd);
    step();
    sample(); check({tag, ".t4_wb_valid"}, wb_valid_o, 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    sample(); sample();
    check("rst.req_valid", bus_req_valid_o, 0);
    check("rst.stall",     stall_o, 0);
    check("rst.wb_valid",  wb_valid_o, 0);
    check("rst.fault",     access_fault_o, 0);
    check("rst.bus_addr",  bus_addr_o, 0);
    check("rst.wb_data",   wb_data_o, 0);
    step(); rst_n = 1'b1;
    sample();

    // Loads with alignment and extension
    do_load("lw",  32'h0000_1000, OP_LW,  5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  32'h0000_1003, OP_LB,  5'd6, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_1003, OP_LBU, 5'd7, 32'h8012_3456, 32'h0000_0080);
    do_load("lh",  32'h0000_1002, OP_LH,  5'd8, 32'h8012_3456, 32'hFFFF_8012);
    do_load("lhu", 32'h0000_1002, OP_LHU, 5'd0, 32'h8012_3456, 32'h0000_8012);
    do_load("lb1", 32'h0000_1001, OP_LB,  5'd9, 32'h8012_3456, 32'h0000_0034);

    // Store with ready held low for three cycles
    step();
    req_mem_i = 1'b1; mem_op_store_i = 1'b1; mem_op_load_i = 1'b0;
    mem_addr_i = 32'h0000_2001; mem_wmask_i = 4'b0010; mem_wdata_i = 32'h0000_AB00;
    sample(); check("sb.t0_stall", stall_o, 1);
    for (int i = 0; i < 4; i++) begin
      step(); drop_req(); bus_req_ready_i = (i == 3);
      sample();
      check("sb.valid", bus_req_valid_o, 1);
      check("sb.addr",  bus_addr_o, 32'h0000_2000);
      check("sb.we",    bus_we_o, 1);
      check("sb.wmask", bus_wmask_o, 4'b0010);
      check("sb.wdata", bus_wdata_o, 32'h0000_AB00);
      check("sb.stall", stall_o, 1);
    end
    step(); bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b1;
    sample();
    check("sb.rsp_stall", stall_o, 0);
    check("sb.rsp_valid", bus_req_valid_o, 0);
    step(); bus_rsp_valid_i = 1'b0;
    sample();
    check("sb.no_wb",    wb_valid_o, 0);
    check("sb.no_fault", access_fault_o, 0);

    // Flush in REQ before ready: request withdrawn, stray response ignored
    step(); present_load(32'h0000_1000, OP_LW, 5'd10);
    sample(); check("fq.t0_stall", stall_o, 1);
    step(); drop_req(); flush_i = 1'b1;
    sample();
    check("fq.t1_valid", bus_req_valid_o, 1);
    check("fq.t1_stall", stall_o, 1);
    step(); flush_i = 1'b0; bus_rsp_valid_i = 1'b1; bus_rdata_i = 32'h0000_1234;
    sample();
    check("fq.t2_valid", bus_req_valid_o, 0);
    check("fq.t2_stall", stall_o, 0);
    step(); bus_rsp_valid_i = 1'b0; bus_rdata_i = '0;
    sample(); check("fq.no_wb", wb_valid_o, 0);

    // Flush together with ready: response must be drained
    step(); present_load(32'h0000_1000, OP_LW, 5'd11);
    step(); drop_req(); flush_i = 1'b1; bus_req_ready_i = 1'b1;
    sample(); check("fqr.t1_valid", bus_req_valid_o, 1);
    step(); flush_i = 1'b0; bus_req_ready_i = 1'b0;
    bus_rsp_valid_i = 1'b1; bus_rdata_i = 32'h0000_1234;
    sample(); check("fqr.drain_stall", stall_o, 1);
    step(); bus_rsp_valid_i = 1'b0; bus_rdata_i = '0;
    sample();
    check("fqr.no_wb", wb_valid_o, 0);
    check("fqr.idle_stall", stall_o, 0);

    // Flush in RESP without response: DRAIN swallows the late response
    step(); present_load(32'h0000_1000, OP_LW, 5'd12); bus_req_ready_i = 1'b1;
    step(); drop_req();
    step(); bus_req_ready_i = 1'b0; flush_i = 1'b1;
    sample(); check("fr.t2_stall", stall_o, 1);
    step(); flush_i = 1'b0;
    sample(); check("fr.drain_stall", stall_o, 1);
    step(); bus_rsp_valid_i = 1'b1; bus_rdata_i = 32'h0000_1234;
    sample(); check("fr.rsp_stall", stall_o, 1);
    step(); bus_rsp_valid_i = 1'b0; bus_rdata_i = '0;
    sample();
    check("fr.no_wb", wb_valid_o, 0);
    check("fr.idle_stall", stall_o, 0);
    check("fr.wb_data_kept", wb_data_o, 32'h0000_0034);

    // Flush and response in the same RESP cycle: flush wins
    step(); present_load(32'h0000_1000, OP_LW, 5'd13); bus_req_ready_i = 1'b1;
    step(); drop_req();
    step(); bus_req_ready_i = 1'b0; flush_i = 1'b1; bus_rsp_valid_i = 1'b1;
    bus_rdata_i = 32'hCAFE_F00D; bus_rsp_err_i = 1'b1;
    step(); flush_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rdata_i = '0; bus_rsp_err_i = 1'b0;
    sample();
    check("frr.no_wb",    wb_valid_o, 0);
    check("frr.no_fault", access_fault_o, 0);
    check("frr.stall",    stall_o, 0);

    // Bus error on a load
    step(); present_load(32'h0000_3000, OP_LW, 5'd14); bus_req_ready_i = 1'b1;
    step(); drop_req();
    step(); bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b1; bus_rsp_err_i = 1'b1;
    bus_rdata_i = 32'h1111_2222;
    step(); bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_rdata_i = '0;
    sample();
    check("err.fault",      access_fault_o, 1);
    check("err.fault_addr", fault_addr_o, 32'h0000_3000);
    check("err.is_store",   fault_is_store_o, 0);
    check("err.no_wb",      wb_valid_o, 0);
    step();
    sample(); check("err.pulse_end", access_fault_o, 0);

    // Misaligned load is never issued
    step(); present_load(32'h0000_1002, OP_LW, 5'd15); misaligned_load_i = 1'b1;
    sample(); check("mis.t0_stall", stall_o, 0);
    step(); drop_req(); misaligned_load_i = 1'b0;
    sample();
    check("mis.t1_valid", bus_req_valid_o, 0);
    check("mis.t1_stall", stall_o, 0);

    // Asynchronous reset while a load waits in RESP
    step(); present_load(32'h0000_4000, OP_LW, 5'd16); bus_req_ready_i = 1'b1;
    step(); drop_req();
    step(); bus_req_ready_i = 1'b0; idle_inputs();
    sample(); check("ar.pre_stall", stall_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar.stall",      stall_o, 0);
    check("ar.req_valid",  bus_req_valid_o, 0);
    check("ar.bus_addr",   bus_addr_o, 0);
    check("ar.wb_data",    wb_data_o, 0);
    check("ar.fault_addr", fault_addr_o, 0);
    check("ar.wb_rd",      wb_rd_o, 0);
    step(); rst_n = 1'b1;
    sample();

    // Recovery from reset back in IDLE
    do_load("post", 32'h0000_1000, OP_LW, 5'd17, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
